maq_mod_counter: RTL and testbench

//  Parametrised two-digit BCD modulo counter: the generic stage behind the clock's seconds,

---
 rtl/maq_mod_counter.sv | 140 ++++++++++++++
 tb/tb_maq_mod_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/maq_mod_counter.sv
// Two-digit BCD modulo counter stage with up/down stepping, preset load and a manual SET mode.
// Optional load range checking is enabled by defining MAQM_LOAD_CHECK_EN.
module maq_mod_counter #(
    parameter int unsigned MODULUS = 60,
    parameter int unsigned MSD_W   = 3
) (
    input  logic             maqm_clock,
    input  logic             maqm_reset,
    input  logic             maqm_enable,
    input  logic             maqm_down,
    input  logic             maqm_load,
    input  logic [3:0]       maqm_load_lsd,
    input  logic [MSD_W-1:0] maqm_load_msd,
    input  logic             maqm_set_mode,
    input  logic             maqm_set_inc,
    output logic [3:0]       maqm_lsd,
    output logic [MSD_W-1:0] maqm_msd,
    output logic             maqm_carry,
    output logic             maqm_borrow,
    output logic             maqm_tc,
    output logic             maqm_setting,
    output logic             maqm_load_err
);

    localparam logic ST_RUN = 1'b0;
    localparam logic ST_SET = 1'b1;

    localparam int unsigned     TERM  = MODULUS - 1;
    localparam logic [3:0]      T_LSD = 4'(TERM % 10);
    localparam logic [MSD_W-1:0] T_MSD = MSD_W'(TERM / 10);

    logic             state_q, state_d;
    logic             inc_q;
    logic [3:0]       lsd_q, lsd_d;
    logic [MSD_W-1:0] msd_q, msd_d;
    logic             at_max, at_zero, is_run, inc_rise, do_step;

    always_comb begin
        at_max   = (lsd_q == T_LSD) && (msd_q == T_MSD);
        at_zero  = (lsd_q == 4'd0) && (msd_q == '0);
        is_run   = (state_q == ST_RUN);
        inc_rise = maqm_set_inc & ~inc_q;
        do_step  = is_run ? maqm_enable : inc_rise;
        state_d  = maqm_set_mode ? ST_SET : ST_RUN;
    end

`ifdef MAQM_LOAD_CHECK_EN
    logic        load_err_q, load_err_d;
    logic        load_ok;
    int unsigned load_val;

    always_comb begin
        load_val = 32'(maqm_load_msd) * 32'd10 + 32'(maqm_load_lsd);
        load_ok  = (maqm_load_lsd <= 4'd9) && (load_val < MODULUS);
    end
`endif

    always_comb begin
        lsd_d = lsd_q;
        msd_d = msd_q;
`ifdef MAQM_LOAD_CHECK_EN
        load_err_d = 1'b0;
`endif
        if (maqm_load) begin
`ifdef MAQM_LOAD_CHECK_EN
            if (load_ok) begin
                lsd_d = maqm_load_lsd;
                msd_d = maqm_load_msd;
            end else begin
                load_err_d = 1'b1;
            end
`else
            lsd_d = maqm_load_lsd;
            msd_d = maqm_load_msd;
`endif
        end else if (do_step) begin
            if (maqm_down) begin
                if (at_zero) begin
                    lsd_d = T_LSD;
                    msd_d = T_MSD;
                end else if (lsd_q == 4'd0) begin
                    lsd_d = 4'd9;
                    msd_d = msd_q - MSD_W'(1);
                end else begin
                    lsd_d = lsd_q - 4'd1;
                end
            end else begin
                if (at_max) begin
                    lsd_d = 4'd0;
                    msd_d = '0;
                end else if (lsd_q == 4'd9) begin
                    lsd_d = 4'd0;
                    msd_d = msd_q + MSD_W'(1);
                end else begin
                    lsd_d = lsd_q + 4'd1;
                end
            end
        end
    end

    // Edge-detect register tracks set_inc in both states so a button already held on entry to
    // SET does not produce a step.
    always_ff @(posedge maqm_clock or negedge maqm_reset) begin
        if (!maqm_reset) begin
            state_q <= ST_RUN;
            inc_q   <= 1'b0;
            lsd_q   <= 4'd0;
            msd_q   <= '0;
        end else begin
            state_q <= state_d;
            inc_q   <= maqm_set_inc;
            lsd_q   <= lsd_d;
            msd_q   <= msd_d;
        end
    end

`ifdef MAQM_LOAD_CHECK_EN
    always_ff @(posedge maqm_clock or negedge maqm_reset) begin
        if (!maqm_reset) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end
    assign maqm_load_err = load_err_q;
`else
    assign maqm_load_err = 1'b0;
`endif

    // Wrap pulses are gated by reset so nothing escapes while the stage is held in reset.
    always_comb begin
        maqm_carry   = maqm_reset & is_run & maqm_enable & ~maqm_load & ~maqm_down & at_max;
        maqm_borrow  = maqm_reset & is_run & maqm_enable & ~maqm_load & maqm_down & at_zero;
        maqm_tc      = maqm_down ? at_zero : at_max;
        maqm_setting = (state_q == ST_SET);
        maqm_lsd     = lsd_q;
        maqm_msd     = msd_q;
    end

endmodule

// File: tb/tb_maq_mod_counter.sv
// Bench for maq_mod_counter: a modulo-60 and a modulo-24 stage driven side by side and checked
// every cycle against an integer-valued reference model.
module tb_maq_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0, down = 1'b0, load = 1'b0, set_mode = 1'b0, set_inc = 1'b0;
    logic [3:0] a_lsd = 4'd0, b_lsd = 4'd0;
    logic [2:0] a_msd = 3'd0;
    logic [1:0] b_msd = 2'd0;

    logic [3:0] lsd60, lsd24;
    logic [2:0] msd60;
    logic [1:0] msd24;
    logic       carry60, borrow60, tc60, setting60, err60;
    logic       carry24, borrow24, tc24, setting24, err24;

    int n_pass = 0, n_total = 0;

    // Reference model state: plain integer values, not digit registers.
    int v60 = 0, v24 = 0;
    bit m_set = 0, m_prev_inc = 0, m_err60 = 0, m_err24 = 0;

    always #5 clk = ~clk;

    maq_mod_counter #(.MODULUS(60), .MSD_W(3)) u_dut60 (
        .maqm_clock(clk), .maqm_reset(rst_n), .maqm_enable(enable), .maqm_down(down),
        .maqm_load(load), .maqm_load_lsd(a_lsd), .maqm_load_msd(a_msd),
        .maqm_set_mode(set_mode), .maqm_set_inc(set_inc), .maqm_lsd(lsd60), .maqm_msd(msd60),
        .maqm_carry(carry60), .maqm_borrow(borrow60), .maqm_tc(tc60),
        .maqm_setting(setting60), .maqm_load_err(err60)
    );

    maq_mod_counter #(.MODULUS(24), .MSD_W(2)) u_dut24 (
        .maqm_clock(clk), .maqm_reset(rst_n), .maqm_enable(enable), .maqm_down(down),
        .maqm_load(load), .maqm_load_lsd(b_lsd), .maqm_load_msd(b_msd),
        .maqm_set_mode(set_mode), .maqm_set_inc(set_inc), .maqm_lsd(lsd24), .maqm_msd(msd24),
        .maqm_carry(carry24), .maqm_borrow(borrow24), .maqm_tc(tc24),
        .maqm_setting(setting24), .maqm_load_err(err24)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int stepped(input int v, input int m, input bit dn);
        return dn ? (v + m - 1) % m : (v + 1) % m;
    endfunction

    function automatic bit load_valid(input int lsd, input int val, input int m);
`ifdef MAQM_LOAD_CHECK_EN
        return (lsd <= 9) && (val < m);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_all();
        bit live = !m_set && enable && !load;
        chk("lsd60", 32'(lsd60), v60 % 10);
        chk("msd60", 32'(msd60), v60 / 10);
        chk("carry60", 32'(carry60), 32'(live && !down && v60 == 59));
        chk("borrow60", 32'(borrow60), 32'(live && down && v60 == 0));
        chk("tc60", 32'(tc60), 32'(down ? v60 == 0 : v60 == 59));
        chk("setting60", 32'(setting60), 32'(m_set));
        chk("err60", 32'(err60), 32'(m_err60));
        chk("lsd24", 32'(lsd24), v24 % 10);
        chk("msd24", 32'(msd24), v24 / 10);
        chk("carry24", 32'(carry24), 32'(live && !down && v24 == 23));
        chk("borrow24", 32'(borrow24), 32'(live && down && v24 == 0));
        chk("tc24", 32'(tc24), 32'(down ? v24 == 0 : v24 == 23));
        chk("setting24", 32'(setting24), 32'(m_set));
        chk("err24", 32'(err24), 32'(m_err24));
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit st = m_set ? (set_inc && !m_prev_inc) : enable;
        int la = int'(a_msd) * 10 + int'(a_lsd);
        int lb = int'(b_msd) * 10 + int'(b_lsd);
        m_err60 = 0;
        m_err24 = 0;
        if (load) begin
            if (load_valid(int'(a_lsd), la, 60)) v60 = la; else m_err60 = 1;
            if (load_valid(int'(b_lsd), lb, 24)) v24 = lb; else m_err24 = 1;
        end else if (st) begin
            v60 = stepped(v60, 60, down);
            v24 = stepped(v24, 24, down);
        end
        m_set = set_mode;
        m_prev_inc = set_inc;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        enable = 0; load = 0; set_inc = 0;
    endtask

    task automatic do_load(input int va, input int vb);
        load = 1;
        a_lsd = 4'(va % 10); a_msd = 3'(va / 10);
        b_lsd = 4'(vb % 10); b_msd = 2'(vb / 10);
    endtask

    task automatic model_reset();
        v60 = 0; v24 = 0; m_set = 0; m_prev_inc = 0; m_err60 = 0; m_err24 = 0;
    endtask

    initial begin
        int saved;
        // Reset state, checked while reset is held.
        #3;
        check_all();
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;

        // Count up through a full modulo-60 cycle (mod-24 stage wraps along the way).
        enable = 1; down = 0;
        repeat (60) cycle();
        chk("wrap60_back_to_0", 32'(msd60) * 10 + 32'(lsd60), 0);

        // Down from 0: borrow, then 59 and 58.
        down = 1;
        repeat (2) cycle();
        chk("down_to_58", 32'(msd60) * 10 + 32'(lsd60), 58);

        // Mod-24 boundaries: 23 -> 00 with carry, 09 -> 10 without.
        down = 0; enable = 0;
        do_load(23, 23); cycle();
        load = 0; enable = 1; cycle();
        enable = 0; do_load(9, 9); cycle();
        load = 0; enable = 1; cycle();
        chk("mod24_09_to_10", 32'(msd24) * 10 + 32'(lsd24), 10);

        // Load with enable in the same cycle: load wins, no carry.
        do_load(45, 15); enable = 1; cycle();
        load = 0; cycle();
        chk("load45_then_46", 32'(msd60) * 10 + 32'(lsd60), 46);

        // SET mode: held button steps once, two pulses step twice, enable ignored.
        idle(); set_mode = 1; cycle();
        saved = v60;
        enable = 1; set_inc = 1;
        repeat (5) cycle();
        set_inc = 0; cycle();
        set_inc = 1; cycle();
        set_inc = 0; cycle();
        set_inc = 1; cycle();
        set_inc = 0; cycle();
        chk("set_plus3", 32'(msd60) * 10 + 32'(lsd60), (saved + 3) % 60);
        idle(); set_mode = 0; cycle();

`ifdef MAQM_LOAD_CHECK_EN
        do_load(12, 12); cycle();
        load = 1; a_lsd = 4'd10; a_msd = 3'd0; b_lsd = 4'd10; b_msd = 2'd0; cycle();
        load = 0; cycle();
        chk("bad_load_keeps_12", 32'(msd60) * 10 + 32'(lsd60), 12);
        do_load(0, 0); a_msd = 3'd6; b_msd = 2'd3; cycle();
        load = 0; repeat (2) cycle();
`endif

        // Randomised traffic with in-range loads.
        for (int i = 0; i < 400; i++) begin
            enable = 1'($urandom_range(0, 1));
            down = ($urandom_range(0, 3) == 0) ? ~down : down;
            set_inc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) set_mode = ~set_mode;
            if ($urandom_range(0, 9) == 0) do_load($urandom_range(0, 59), $urandom_range(0, 23));
            else load = 0;
            cycle();
        end

        // Reset asserted mid-count while in SET: outputs clear immediately, no pulses.
        idle(); set_mode = 1; cycle();
        do_load(37, 17); cycle();
        load = 0; enable = 1; down = 1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_lsd", 32'(lsd60), 0);
        chk("rst_msd", 32'(msd60), 0);
        chk("rst_setting", 32'(setting60), 0);
        chk("rst_borrow", 32'(borrow60), 0);
        chk("rst_borrow24", 32'(borrow24), 0);
        set_mode = 0; enable = 0; down = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        enable = 1;
        repeat (5) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
